// File: rtl/mcpu_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset core: opcodes, functs, FSM states, ALU ops.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package mcpu_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

    // R-type field view of an instruction word; I/J fields are derived below.
    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } instr_t;

    function automatic logic [15:0] instr_imm(input instr_t i);
        return {i.rd, i.shamt, i.funct};
    endfunction

    function automatic logic [25:0] instr_jidx(input instr_t i);
        return {i.rs, i.rt, i.rd, i.shamt, i.funct};
    endfunction

    function automatic logic instr_legal(input instr_t i);
        logic ok;
        ok = 1'b0;
        case (i.opcode)
            OP_RTYPE: ok = (i.funct == FN_ADD) || (i.funct == FN_SUB) ||
                           (i.funct == FN_AND) || (i.funct == FN_OR)  ||
                           (i.funct == FN_SLT);
            OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic alu_op_e funct_to_alu(input logic [5:0] funct);
        alu_op_e op;
        case (funct)
            FN_SUB:  op = ALU_SUB;
            FN_AND:  op = ALU_AND;
            FN_OR:   op = ALU_OR;
            FN_SLT:  op = ALU_SLT;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mcpu_regfile.sv
// 32 x XLEN register file; register 0 is hardwired to zero.
// Latency: reads are combinational, a write lands at the next posedge.
// Backpressure: none; the write port is accepted on every cycle we is high.
//
// Ports: clk, rst (sync, active-high, clears all registers);
//        we/waddr/wdata write port; raddr_a/rdata_a, raddr_b/rdata_b read ports.
module mcpu_regfile #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr_a,
    input  logic [4:0]      raddr_b,
    output logic [XLEN-1:0] rdata_a,
    output logic [XLEN-1:0] rdata_b
);

    // Entry 0 has no storage at all, so writes to it vanish by construction.
    logic [31:1][XLEN-1:0] regs_q;
    logic [31:1][XLEN-1:0] regs_d;

    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != 5'd0)) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata_a = (raddr_a == 5'd0) ? '0 : regs_q[raddr_a];
    assign rdata_b = (raddr_b == 5'd0) ? '0 : regs_q[raddr_b];

endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle MIPS-subset core (add/sub/and/or/slt, lw, sw, beq, addi, j) on one memory port.
// Latency: j 2, beq 3, R/addi/sw 4, lw 5 cycles with zero-wait memory; +1 per wait cycle.
// Backpressure: mem_req holds with address/we/wdata frozen until mem_ready; FSM stalls meanwhile.
//
// Ports: clk, rst (sync, active-high); mem_req/mem_we/mem_addr/mem_wdata out, mem_rdata/mem_ready in;
//        retire/retire_pc one pulse per completed instruction; halted (trap build only).
// Build option: define CPU_ILLEGAL_TRAP_EN to stop in a halt state on an unknown encoding;
//        otherwise unknown encodings retire as NOPs from DECODE and halted is tied low.
module multicycle_cpu
    import mcpu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              AW       = 32,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic            retire,
    output logic [AW-1:0]   retire_pc,
    output logic            halted
);

    // Bits of the PC replaced by a jump target; upper bits come from the current region.
    localparam logic [AW-1:0] JMASK = AW'(32'h0FFF_FFFF);

    state_e          state_q,     state_d;
    logic [AW-1:0]   pc_q,        pc_d;
    logic [AW-1:0]   instr_pc_q,  instr_pc_d;
    instr_t          ir_q,        ir_d;
    logic [XLEN-1:0] a_q,         a_d;
    logic [XLEN-1:0] b_q,         b_d;
    logic [XLEN-1:0] alu_out_q,   alu_out_d;
    logic [XLEN-1:0] mdr_q,       mdr_d;

    logic [XLEN-1:0] rf_rdata_a;
    logic [XLEN-1:0] rf_rdata_b;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;

    logic [15:0]     imm16;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_res;
    alu_op_e         alu_op;
    logic [AW-1:0]   pc_plus4;
    logic [AW-1:0]   br_target;
    logic [AW-1:0]   j_target;
    logic [AW-1:0]   addr_raw;
    logic            is_rtype;
    logic            req_c;
    logic            we_c;
    logic            use_alu_addr;
    logic            retire_c;

    mcpu_regfile #(
        .XLEN (XLEN)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (ir_q.rs),
        .raddr_b (ir_q.rt),
        .rdata_a (rf_rdata_a),
        .rdata_b (rf_rdata_b)
    );

    // Sign extension, ALU and next-PC candidates
    assign is_rtype  = (ir_q.opcode == OP_RTYPE);
    assign imm16     = instr_imm(ir_q);
    assign imm_ext   = {{(XLEN-16){imm16[15]}}, imm16};
    assign alu_b     = is_rtype ? b_q : imm_ext;
    assign alu_op    = is_rtype ? funct_to_alu(ir_q.funct) : ALU_ADD;

    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ADD: alu_res = a_q + alu_b;
            ALU_SUB: alu_res = a_q - alu_b;
            ALU_AND: alu_res = a_q & alu_b;
            ALU_OR:  alu_res = a_q | alu_b;
            ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(alu_b))};
            default: alu_res = '0;
        endcase
    end

    // pc_q already points past the current instruction once FETCH completes.
    assign pc_plus4  = pc_q + AW'(4);
    assign br_target = pc_q + (imm_ext[AW-1:0] << 2);
    assign j_target  = (pc_q & ~JMASK) | (AW'({instr_jidx(ir_q), 2'b00}) & JMASK);

    // Next-state and datapath control
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_pc_d   = instr_pc_q;
        ir_d         = ir_q;
        a_d          = a_q;
        b_d          = b_q;
        alu_out_d    = alu_out_q;
        mdr_d        = mdr_q;
        req_c        = 1'b0;
        we_c         = 1'b0;
        use_alu_addr = 1'b0;
        retire_c     = 1'b0;
        rf_we        = 1'b0;
        rf_waddr     = is_rtype ? ir_q.rd : ir_q.rt;
        rf_wdata     = (ir_q.opcode == OP_LW) ? mdr_q : alu_out_q;

        case (state_q)
            ST_FETCH: begin
                req_c = 1'b1;
                if (mem_ready) begin
                    ir_d       = instr_t'(mem_rdata[31:0]);
                    instr_pc_d = pc_q;
                    pc_d       = pc_plus4;
                    state_d    = ST_DECODE;
                end
            end

            ST_DECODE: begin
                a_d = rf_rdata_a;
                b_d = rf_rdata_b;
                if (!instr_legal(ir_q)) begin
`ifdef CPU_ILLEGAL_TRAP_EN
                    state_d = ST_HALT;
`else
                    retire_c = 1'b1;
                    state_d  = ST_FETCH;
`endif
                end else if (ir_q.opcode == OP_J) begin
                    pc_d     = j_target;
                    retire_c = 1'b1;
                    state_d  = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                alu_out_d = alu_res;
                if (ir_q.opcode == OP_BEQ) begin
                    if (a_q == b_q) begin
                        pc_d = br_target;
                    end
                    retire_c = 1'b1;
                    state_d  = ST_FETCH;
                end else if ((ir_q.opcode == OP_LW) || (ir_q.opcode == OP_SW)) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end

            ST_MEM: begin
                req_c        = 1'b1;
                use_alu_addr = 1'b1;
                we_c         = (ir_q.opcode == OP_SW);
                if (mem_ready) begin
                    if (ir_q.opcode == OP_SW) begin
                        retire_c = 1'b1;
                        state_d  = ST_FETCH;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = ST_WB;
                    end
                end
            end

            ST_WB: begin
                rf_we    = 1'b1;
                retire_c = 1'b1;
                state_d  = ST_FETCH;
            end

            ST_HALT: begin
                state_d = ST_HALT;
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            instr_pc_q <= '0;
            ir_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            alu_out_q  <= '0;
            mdr_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_pc_q <= instr_pc_d;
            ir_q       <= ir_d;
            a_q        <= a_d;
            b_q        <= b_d;
            alu_out_q  <= alu_out_d;
            mdr_q      <= mdr_d;
        end
    end

    // Port outputs. Reset masks the request so an in-flight transfer is dropped at once.
    // Addresses are sourced from registers only, so they cannot move during a stall.
    assign addr_raw  = use_alu_addr ? alu_out_q[AW-1:0] : pc_q;
    assign mem_addr  = {addr_raw[AW-1:2], 2'b00};
    assign mem_req   = req_c & ~rst;
    assign mem_we    = we_c & ~rst;
    assign mem_wdata = b_q;
    assign retire    = retire_c & ~rst;
    assign retire_pc = instr_pc_q;

`ifdef CPU_ILLEGAL_TRAP_EN
    assign halted = (state_q == ST_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_cpu.sv
// Bench for multicycle_cpu: wait-state memory, ISA-level reference model, per-cycle compare.
// Latency: n/a.
// Backpressure: memory inserts per-instruction wait cycles to stall the core.
module tb_multicycle_cpu;

    localparam int XLEN = 32;
    localparam int AW   = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ready;
    logic            retire;
    logic [AW-1:0]   retire_pc;
    logic            halted;

    always #5 clk = ~clk;

    multicycle_cpu #(
        .XLEN     (XLEN),
        .AW       (AW),
        .RESET_PC (32'h0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .retire    (retire),
        .retire_pc (retire_pc),
        .halted    (halted)
    );

    localparam logic [31:0] ILL_PC = 32'h140;
    localparam logic [31:0] END_PC = 32'h154;

    logic [31:0] dmem [0:255];   // memory seen by the DUT
    logic [31:0] mm   [0:255];   // reference model memory
    logic [31:0] rf   [0:31];    // reference model registers
    logic [31:0] model_pc;

    int cmp_n = 0;
    int err_n = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] idx);
        return {6'h02, idx};
    endfunction

    task automatic put(input logic [31:0] addr, input logic [31:0] w);
        dmem[addr[9:2]] = w;
        mm[addr[9:2]]   = w;
    endtask

    // Wait cycles the memory inserts on every access belonging to the instruction at pc.
    function automatic int wait_for(input logic [31:0] pc);
        if (pc == 32'h0C || pc == 32'h20) return 3;
        if (pc >= 32'h100 && pc < 32'h110) return 1;
        return 0;
    endfunction

    task automatic wr(input logic [4:0] r, input logic [31:0] v);
        if (r != 5'd0) rf[r] = v;
    endtask

    // Executes the instruction at model_pc architecturally; base = zero-wait cycle count.
    task automatic model_step(output int base);
        logic [31:0] ins, a, b, imm, ea, nxt;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd;
        ins = mm[model_pc[9:2]];
        op  = ins[31:26];
        rs  = ins[25:21];
        rt  = ins[20:16];
        rd  = ins[15:11];
        fn  = ins[5:0];
        imm = {{16{ins[15]}}, ins[15:0]};
        a   = rf[rs];
        b   = rf[rt];
        ea  = (a + imm) & 32'hFFFF_FFFC;
        nxt = model_pc + 32'd4;
        base = 2;
        case (op)
            6'h00: begin
                base = 4;
                case (fn)
                    6'h20: wr(rd, a + b);
                    6'h22: wr(rd, a - b);
                    6'h24: wr(rd, a & b);
                    6'h25: wr(rd, a | b);
                    6'h2A: wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                    default: base = 2;
                endcase
            end
            6'h08: begin base = 4; wr(rt, a + imm); end
            6'h23: begin base = 5; wr(rt, mm[ea[9:2]]); end
            6'h2B: begin base = 4; mm[ea[9:2]] = b; end
            6'h04: begin base = 3; if (a == b) nxt = model_pc + 32'd4 + (imm << 2); end
            6'h02: begin base = 2; nxt = {nxt[31:28], ins[25:0], 2'b00}; end
            default: base = 2;
        endcase
        model_pc = nxt;
    endtask

    logic [31:0] exp_pcs [0:9];

    initial begin
        int          cyc, last_ret, waits, nret, cnt, base, trap_cyc;
        logic        done, prev_stall, prev_ret, prev_we;
        logic [31:0] prev_addr, prev_wdata;

        exp_pcs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h1C, 32'h20, 32'h24, 32'h100, 32'h104};
        for (int i = 0; i < 256; i++) begin dmem[i] = 32'h0; mm[i] = 32'h0; end
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        model_pc = 32'h0;

        put(32'h000, enc_i(6'h08, 5'd0, 5'd1, 16'd5));          // addi $1,$0,5
        put(32'h004, enc_i(6'h08, 5'd0, 5'd2, 16'd7));          // addi $2,$0,7
        put(32'h008, enc_r(5'd1, 5'd2, 5'd3, 6'h20));           // add  $3,$1,$2
        put(32'h00C, enc_i(6'h2B, 5'd0, 5'd3, 16'h0008));       // sw   $3,8($0)
        put(32'h010, enc_i(6'h04, 5'd1, 5'd1, 16'd2));          // beq  $1,$1,+2
        put(32'h014, enc_i(6'h08, 5'd0, 5'd20, 16'h55));        // skipped
        put(32'h018, enc_i(6'h08, 5'd0, 5'd20, 16'h55));        // skipped
        put(32'h01C, enc_i(6'h04, 5'd1, 5'd2, 16'd3));          // beq  $1,$2 (not taken)
        put(32'h020, enc_i(6'h23, 5'd0, 5'd4, 16'h0008));       // lw   $4,8($0)
        put(32'h024, enc_j(26'h40));                             // j    0x40 -> 0x100
        put(32'h100, enc_r(5'd1, 5'd2, 5'd0, 6'h20));           // add  $0,$1,$2
        put(32'h104, enc_i(6'h08, 5'd0, 5'd7, 16'd1));          // addi $7,$0,1
        put(32'h108, enc_r(5'd0, 5'd7, 5'd5, 6'h22));           // sub  $5,$0,$7
        put(32'h10C, enc_r(5'd5, 5'd7, 5'd6, 6'h2A));           // slt  $6,$5,$7
        put(32'h110, enc_r(5'd1, 5'd2, 5'd8, 6'h24));           // and  $8,$1,$2
        put(32'h114, enc_r(5'd1, 5'd2, 5'd9, 6'h25));           // or   $9,$1,$2
        put(32'h118, enc_i(6'h08, 5'd0, 5'd11, 16'hFFFD));      // addi $11,$0,-3
        put(32'h11C, enc_i(6'h2B, 5'd0, 5'd4, 16'h0200));       // sw   $4,0x200
        put(32'h120, enc_i(6'h2B, 5'd0, 5'd0, 16'h0204));       // sw   $0,0x204
        put(32'h124, enc_i(6'h2B, 5'd0, 5'd5, 16'h0208));       // sw   $5,0x208
        put(32'h128, enc_i(6'h2B, 5'd0, 5'd6, 16'h020C));       // sw   $6,0x20C
        put(32'h12C, enc_i(6'h2B, 5'd0, 5'd8, 16'h0210));       // sw   $8,0x210
        put(32'h130, enc_i(6'h2B, 5'd0, 5'd9, 16'h0214));       // sw   $9,0x214
        put(32'h134, enc_i(6'h2B, 5'd0, 5'd11, 16'h0218));      // sw   $11,0x218
        put(32'h138, enc_i(6'h23, 5'd0, 5'd13, 16'h021B));      // lw   $13,0x21B (misaligned)
        put(32'h13C, enc_i(6'h2B, 5'd0, 5'd13, 16'h021C));      // sw   $13,0x21C
        put(ILL_PC,  32'hFC00_0000);                             // opcode 0x3F
        put(32'h144, enc_i(6'h08, 5'd0, 5'd12, 16'd9));         // addi $12,$0,9
        put(32'h148, enc_i(6'h2B, 5'd0, 5'd12, 16'h0220));      // sw   $12,0x220
        put(32'h14C, enc_r(5'd7, 5'd5, 5'd14, 6'h2A));          // slt  $14,$7,$5
        put(32'h150, enc_i(6'h2B, 5'd0, 5'd14, 16'h0224));      // sw   $14,0x224
        put(END_PC,  enc_j(26'h55));                             // j    self
        put(32'h204, 32'hBEEF);
        put(32'h224, 32'hDEAD);

        mem_ready = 1'b0;
        mem_rdata = '0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_mem_req",   mem_req,   1'b0);
        chk("reset_mem_we",    mem_we,    1'b0);
        chk("reset_retire",    retire,    1'b0);
        chk("reset_halted",    halted,    1'b0);
        chk("reset_mem_addr",  mem_addr,  32'h0);
        chk("reset_retire_pc", retire_pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("first_mem_req",  mem_req,  1'b1);
        chk("first_mem_addr", mem_addr, 32'h0);
        chk("first_mem_we",   mem_we,   1'b0);

        cyc = 0; last_ret = 0; waits = 0; nret = 0; cnt = 0; trap_cyc = 0;
        done = 1'b0; prev_stall = 1'b0; prev_ret = 1'b0; prev_we = 1'b0;
        prev_addr = '0; prev_wdata = '0;

        for (int t = 0; t < 4000 && !done; t++) begin
            // memory responder
            if (mem_req) begin
                if (cnt >= wait_for(model_pc)) begin
                    mem_ready = 1'b1;
                    mem_rdata = dmem[mem_addr[9:2]];
                    if (mem_we) dmem[mem_addr[9:2]] = mem_wdata;
                    cnt = 0;
                end else begin
                    mem_ready = 1'b0;
                    cnt++;
                end
            end else begin
                mem_ready = 1'b0;
                cnt = 0;
            end
            #1;
            cyc++;

            if (prev_stall) begin
                chk("stall_req_held", mem_req,  1'b1);
                chk("stall_addr",     mem_addr, prev_addr);
                chk("stall_we",       mem_we,   prev_we);
                if (prev_we) chk("stall_wdata", mem_wdata, prev_wdata);
            end
            prev_stall = mem_req && !mem_ready;
            prev_addr  = mem_addr;
            prev_we    = mem_we;
            prev_wdata = mem_wdata;
            if (prev_stall) waits++;

`ifndef CPU_ILLEGAL_TRAP_EN
            chk("halted_low", halted, 1'b0);
`endif

            if (retire) begin
                chk("retire_not_back_to_back", prev_ret, 1'b0);
`ifdef CPU_ILLEGAL_TRAP_EN
                if (model_pc == ILL_PC) chk("retire_on_trap", retire, 1'b0);
`endif
                chk("retire_pc", retire_pc, model_pc);
                if (nret < 10) chk($sformatf("retire_pc_lit%0d", nret), retire_pc, exp_pcs[nret]);
                model_step(base);
                chk($sformatf("latency_pc%0h", retire_pc), cyc - last_ret, base + waits);
                if (nret == 2) chk("three_retires_cycles", cyc, 12);
                nret++;
                last_ret = cyc;
                waits    = 0;
                if (model_pc == END_PC) done = 1'b1;
            end
            prev_ret = retire;

`ifdef CPU_ILLEGAL_TRAP_EN
            if (model_pc == ILL_PC) begin
                trap_cyc++;
                if (trap_cyc > 3) begin
                    chk("trap_halted",  halted,  1'b1);
                    chk("trap_mem_req", mem_req, 1'b0);
                    chk("trap_retire",  retire,  1'b0);
                    if (trap_cyc > 12) done = 1'b1;
                end
            end
`endif

            if (!done) begin
                @(negedge clk);
                #1;
            end
        end

        if (!done) begin
            cmp_n++;
            err_n++;
            $display("FAIL timeout: program did not complete, retired %0d instructions, model pc 0x%0h",
                     nret, model_pc);
        end

        // Hand-computed architectural results
        chk("mem_08_sw",       dmem[32'h008 >> 2], 32'd12);
        chk("mem_200_lw",      dmem[32'h200 >> 2], 32'd12);
        chk("mem_204_r0",      dmem[32'h204 >> 2], 32'd0);
        chk("mem_208_sub",     dmem[32'h208 >> 2], 32'hFFFF_FFFF);
        chk("mem_20C_slt",     dmem[32'h20C >> 2], 32'd1);
        chk("mem_210_and",     dmem[32'h210 >> 2], 32'd5);
        chk("mem_214_or",      dmem[32'h214 >> 2], 32'd7);
        chk("mem_218_addi",    dmem[32'h218 >> 2], 32'hFFFF_FFFD);
        chk("mem_21C_misalign", dmem[32'h21C >> 2], 32'hFFFF_FFFD);
`ifdef CPU_ILLEGAL_TRAP_EN
        chk("mem_220_untouched", dmem[32'h220 >> 2], 32'd0);
        chk("mem_224_untouched", dmem[32'h224 >> 2], 32'hDEAD);
`else
        chk("mem_220_after_nop", dmem[32'h220 >> 2], 32'd9);
        chk("mem_224_slt_zero",  dmem[32'h224 >> 2], 32'd0);
`endif
        for (int i = 0; i < 256; i++) begin
            if (dmem[i] !== mm[i]) chk($sformatf("mem_word_%0h", i * 4), dmem[i], mm[i]);
        end
        chk("mem_image_words", 64'(cmp_n) - 64'(cmp_n) + 64'(mm_mismatch()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

    function automatic int mm_mismatch();
        int n;
        n = 0;
        for (int i = 0; i < 256; i++) if (dmem[i] !== mm[i]) n++;
        return n;
    endfunction

endmodule
